// File: rtl/ps2_key_receiver_if.sv
// PS/2 pin pair plus the decoded key-event outputs of the receiver.
interface ps2_key_receiver_if;
  logic       ps2_clock;
  logic       ps2_data;
  logic       ps2_key_pressed;
  logic       key_released;
  logic [7:0] ps2_out;
  logic       key_extended;
  logic       frame_error;

  modport master (
    output ps2_clock, ps2_data,
    input  ps2_key_pressed, key_released, ps2_out, key_extended, frame_error
  );
  modport slave (
    input  ps2_clock, ps2_data,
    output ps2_key_pressed, key_released, ps2_out, key_extended, frame_error
  );
endinterface

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard frame receiver: synchronises the raw lines, deframes 11-bit
// frames, folds E0/F0 prefixes into make/break events and flags bad frames.
module ps2_key_receiver #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int CNT_W          = 16
) (
  input logic              iCLK,
  input logic              iRST,
  ps2_key_receiver_if.slave bus
);
  typedef enum logic [2:0] {S_WAIT_IDLE, S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  localparam logic [CNT_W-1:0] LP_TO = CNT_W'(TIMEOUT_CYCLES);

  state_t           r_state, w_state_nx;
  logic             r_clk_m, r_clk_s, r_clk_d, r_dat_m, r_dat_s;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx, w_cnt_inc;
  logic [2:0]       r_bit, w_bit_nx;
  logic [7:0]       r_sh, w_sh_nx;
  logic             r_par, w_par_nx;
  logic             r_ext, w_ext_nx, r_brk, w_brk_nx;
  logic [7:0]       r_out, w_out_nx;
  logic             r_kext, w_kext_nx;
  logic             r_press, w_press_nx, r_rel, w_rel_nx, r_err, w_err_nx;
  logic             w_fall, w_to;

  assign w_fall    = r_clk_d & ~r_clk_s;
  assign w_to      = (r_cnt >= LP_TO);
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_clk_m <= 1'b1; r_clk_s <= 1'b1; r_clk_d <= 1'b1;
      r_dat_m <= 1'b1; r_dat_s <= 1'b1;
      r_state <= S_WAIT_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_sh    <= '0;
      r_par   <= 1'b0;
      r_ext   <= 1'b0;
      r_brk   <= 1'b0;
      r_out   <= 8'h00;
      r_kext  <= 1'b0;
      r_press <= 1'b0;
      r_rel   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_clk_m <= bus.ps2_clock; r_clk_s <= r_clk_m; r_clk_d <= r_clk_s;
      r_dat_m <= bus.ps2_data;  r_dat_s <= r_dat_m;
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_bit   <= w_bit_nx;
      r_sh    <= w_sh_nx;
      r_par   <= w_par_nx;
      r_ext   <= w_ext_nx;
      r_brk   <= w_brk_nx;
      r_out   <= w_out_nx;
      r_kext  <= w_kext_nx;
      r_press <= w_press_nx;
      r_rel   <= w_rel_nx;
      r_err   <= w_err_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_bit_nx   = r_bit;
    w_sh_nx    = r_sh;
    w_par_nx   = r_par;
    w_ext_nx   = r_ext;
    w_brk_nx   = r_brk;
    w_out_nx   = r_out;
    w_kext_nx  = r_kext;
    w_press_nx = 1'b0;
    w_rel_nx   = 1'b0;
    w_err_nx   = 1'b0;
    case (r_state)
      S_WAIT_IDLE: begin
        // Edges are deliberately ignored here so a cut frame's tail cannot start one.
        if (w_to) begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = '0;
        end else if (r_clk_s) w_cnt_nx = w_cnt_inc;
        else                  w_cnt_nx = '0;
      end
      S_IDLE: begin
        w_cnt_nx = '0;
        if (w_fall) begin
          if (!r_dat_s) begin
            w_state_nx = S_DATA;
            w_bit_nx   = '0;
          end else begin
            w_err_nx   = 1'b1;
            w_state_nx = S_WAIT_IDLE;
          end
        end
      end
      default: begin
        // Timeout takes priority over an edge landing in the same cycle.
        if (w_to) begin
          w_err_nx   = 1'b1;
          w_state_nx = S_WAIT_IDLE;
          w_cnt_nx   = '0;
        end else if (w_fall) begin
          w_cnt_nx = '0;
          if (r_state == S_DATA) begin
            w_sh_nx[r_bit] = r_dat_s;
            if (r_bit == 3'd7) w_state_nx = S_PARITY;
            else               w_bit_nx   = r_bit + 3'd1;
          end else if (r_state == S_PARITY) begin
            w_par_nx   = r_dat_s;
            w_state_nx = S_STOP;
          end else begin
            w_state_nx = S_IDLE;
            if (r_dat_s && (^{r_sh, r_par})) begin
              if (r_sh == 8'hE0)      w_ext_nx = 1'b1;
              else if (r_sh == 8'hF0) w_brk_nx = 1'b1;
              else begin
                w_out_nx   = r_sh;
                w_kext_nx  = r_ext;
                w_rel_nx   = r_brk;
                w_press_nx = ~r_brk;
                w_ext_nx   = 1'b0;
                w_brk_nx   = 1'b0;
              end
            end else w_err_nx = 1'b1;
          end
        end else w_cnt_nx = w_cnt_inc;
      end
    endcase
    if (w_err_nx) begin
      w_ext_nx = 1'b0;
      w_brk_nx = 1'b0;
    end
  end

  assign bus.ps2_key_pressed = r_press;
  assign bus.key_released    = r_rel;
  assign bus.ps2_out         = r_out;
  assign bus.key_extended    = r_kext;
  assign bus.frame_error     = r_err;
endmodule

// File: tb/tb_ps2_key_receiver.sv
// Directed bench: frame-level model predicts key events and errors with their
// cycle of appearance; a per-cycle compare checks every DUT output.
module tb_ps2_key_receiver;
  localparam int T = 200;
  localparam int H = 4;
  localparam int K_P = 0, K_R = 1, K_E = 2, K_RST = 3;

  typedef struct {
    int         cyc;
    int         kind;
    logic [7:0] code;
    logic       ext;
  } ev_t;

  logic iCLK = 1'b0;
  logic iRST = 1'b1;
  ps2_key_receiver_if bus();

  ps2_key_receiver #(.TIMEOUT_CYCLES(T), .CNT_W(16)) dut (
    .iCLK(iCLK),
    .iRST(iRST),
    .bus (bus)
  );

  always #5 iCLK = ~iCLK;

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  bit   chk_en = 0;
  ev_t  q[$];
  logic [7:0] mout = 8'h00;
  logic       mext = 1'b0;
  bit   m_armed = 0, m_ext = 0, m_brk = 0, frame_ok = 0;
  int   last_drv = 0;

  always @(posedge iCLK) cyc <= cyc + 1;

  // Per-cycle compare against the event queue.
  always @(negedge iCLK) begin
    if (chk_en) begin
      logic ep, er, ee;
      ev_t  ev;
      ep = 1'b0; er = 1'b0; ee = 1'b0;
      while (q.size() > 0 && q[0].cyc < cyc) begin
        ev = q.pop_front();
        tests++; fails++;
        $display("FAIL missed_event kind=%0d expected_cyc=%0d now=%0d", ev.kind, ev.cyc, cyc);
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        ev = q.pop_front();
        case (ev.kind)
          K_P:     begin ep = 1'b1; mout = ev.code; mext = ev.ext; end
          K_R:     begin er = 1'b1; mout = ev.code; mext = ev.ext; end
          K_E:     ee = 1'b1;
          default: begin mout = 8'h00; mext = 1'b0; end
        endcase
      end
      tests++;
      if (bus.ps2_key_pressed !== ep || bus.key_released !== er || bus.frame_error !== ee ||
          bus.ps2_out !== mout || bus.key_extended !== mext) begin
        fails++;
        $display("FAIL cycle_cmp cyc=%0d got p/r/e=%b%b%b out=%h ext=%b want p/r/e=%b%b%b out=%h ext=%b",
                 cyc, bus.ps2_key_pressed, bus.key_released, bus.frame_error, bus.ps2_out,
                 bus.key_extended, ep, er, ee, mout, mext);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge iCLK);
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h want=%h", name, got, exp);
    end
  endtask

  task automatic push(input int c, input int k, input logic [7:0] code, input logic ext);
    ev_t e;
    e.cyc = c; e.kind = k; e.code = code; e.ext = ext;
    q.push_back(e);
  endtask

  task automatic fall(input logic b);
    bus.ps2_data = b;
    tick(2);
    bus.ps2_clock = 1'b0;
    last_drv = cyc;
  endtask

  task automatic rise();
    tick(H);
    bus.ps2_clock = 1'b1;
    tick(H - 2);
  endtask

  // Sends frame bit indices first..last of byte d; stall marks a deliberately abandoned frame.
  task automatic send_bits(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                           input int first, input int last, input bit stall);
    logic [10:0] b;
    b[0] = 1'b0;
    b[8:1] = d;
    b[9] = ~(^d) ^ bad_par;
    b[10] = ~bad_stop;
    if (first == 0) frame_ok = m_armed;
    for (int i = first; i <= last; i++) begin
      fall(b[i]);
      if (i == 10 && frame_ok) begin
        if (b[10] && (^b[9:1])) begin
          if (d == 8'hE0)      m_ext = 1;
          else if (d == 8'hF0) m_brk = 1;
          else begin
            push(last_drv + 3, m_brk ? K_R : K_P, d, m_ext);
            m_ext = 0; m_brk = 0;
          end
        end else begin
          push(last_drv + 3, K_E, 8'h00, 1'b0);
          m_ext = 0; m_brk = 0;
        end
        frame_ok = 0;
      end
      if (i == last && i < 10 && stall && frame_ok) begin
        push(last_drv + 4 + T, K_E, 8'h00, 1'b0);
        m_ext = 0; m_brk = 0; m_armed = 0; frame_ok = 0;
      end
      rise();
    end
  endtask

  task automatic send(input logic [7:0] d, input bit bad_par, input bit bad_stop);
    send_bits(d, bad_par, bad_stop, 0, 10, 1'b0);
  endtask

  task automatic arm();
    tick(T + 10);
    m_armed = 1;
  endtask

  task automatic do_reset();
    iRST = 1'b1;
    push(cyc + 1, K_RST, 8'h00, 1'b0);
    m_armed = 0; m_ext = 0; m_brk = 0; frame_ok = 0;
    tick(2);
    iRST = 1'b0;
  endtask

  initial begin
    bus.ps2_clock = 1'b1;
    bus.ps2_data  = 1'b1;
    tick(3);
    iRST = 1'b0;
    tick(1);
    check("rst_out", bus.ps2_out, 8'h00);
    check("rst_flags", {4'h0, bus.ps2_key_pressed, bus.key_released, bus.key_extended, bus.frame_error}, 8'h00);
    chk_en = 1;

    // Frame before the idle window: ignored.
    send(8'h1C, 0, 0);
    arm();
    send(8'h1C, 0, 0);
    tick(4);
    check("make_1C_out", bus.ps2_out, 8'h1C);
    check("make_1C_ext", {7'h0, bus.key_extended}, 8'h00);

    send(8'hF0, 0, 0);
    send(8'h1C, 0, 0);
    tick(4);
    check("break_1C_out", bus.ps2_out, 8'h1C);

    send(8'hE0, 0, 0);
    send(8'h75, 0, 0);
    tick(4);
    check("ext_make_out", bus.ps2_out, 8'h75);
    check("ext_make_ext", {7'h0, bus.key_extended}, 8'h01);
    send(8'hE0, 0, 0);
    send(8'hF0, 0, 0);
    send(8'h75, 0, 0);

    // Parity error, then stop-bit error, surrounding a good frame.
    send(8'hE0, 0, 0);
    send(8'h1C, 1, 0);
    tick(4);
    check("par_err_hold_out", bus.ps2_out, 8'h75);
    send(8'h1D, 0, 0);
    send(8'h1E, 0, 1);
    tick(4);
    check("stop_err_hold_out", bus.ps2_out, 8'h1D);
    check("after_err_ext", {7'h0, bus.key_extended}, 8'h00);

    // Start-bit error: edge with data high in IDLE.
    fall(1'b1);
    if (m_armed) begin
      push(last_drv + 3, K_E, 8'h00, 1'b0);
      m_armed = 0; m_ext = 0; m_brk = 0;
    end
    rise();
    send(8'h16, 0, 0);
    arm();
    send(8'hAA, 0, 0);

    // Stall after start + 4 data bits.
    send_bits(8'h4D, 0, 0, 0, 4, 1'b1);
    tick(T + 10);
    send(8'h2A, 0, 0);
    arm();
    send(8'h29, 0, 0);
    tick(4);
    check("after_timeout_out", bus.ps2_out, 8'h29);

    // Reset mid-frame with ext pending.
    send(8'hE0, 0, 0);
    send_bits(8'h33, 0, 0, 0, 4, 1'b0);
    do_reset();
    tick(1);
    check("midrst_out", bus.ps2_out, 8'h00);
    send_bits(8'h33, 0, 0, 5, 10, 1'b0);
    arm();
    send(8'h2B, 0, 0);
    tick(4);
    check("post_rst_out", bus.ps2_out, 8'h2B);
    check("post_rst_ext", {7'h0, bus.key_extended}, 8'h00);

    tick(T + 20);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL pending_events got=%0d want=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
